// File: rtl/kalman_pkg.sv
// kalman_pkg: shared defaults, FSM encoding and saturating add for kalman_filter_mc
package kalman_pkg;
   localparam int          FRAC_DEF   = 13;
   localparam logic [31:0] P_INIT_DEF = 32'd100000;
   localparam logic [31:0] Q_DEF      = 32'd5;
   localparam logic [31:0] R_DEF      = 32'd10;
   typedef enum logic [2:0] {IDLE, PRED, DIV, UPD, OUT} state_t;
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hffff_ffff : s[31:0];
   endfunction
endpackage

// File: rtl/kalman_div_seq.sv
// kalman_div_seq: restoring divider, one quotient bit per cycle, fixed QW-cycle run
module kalman_div_seq #(
   parameter int DW = 45,
   parameter int VW = 32,
   parameter int QW = 14
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic [DW-1:0] i_dividend,
   input  logic [VW-1:0] i_divisor,
   output logic          o_done,
   output logic [QW-1:0] o_quot
);
   localparam int CW = $clog2(QW);
   logic [VW-1:0] rem;
   logic [VW-1:0] dvs;
   logic [QW-1:0] sh;
   logic [CW-1:0] cnt;
   logic          busy;
   logic [VW:0]   trial;
   logic          ge;
   assign trial  = {rem, sh[QW-1]};
   assign ge     = trial >= {1'b0, dvs};
   assign o_done = busy && cnt == CW'(QW - 1);
   // The caller guarantees the top dividend bits are below the divisor, so only QW steps are needed.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rem    <= '0;
         dvs    <= '0;
         sh     <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         o_quot <= '0;
      end else if (i_start) begin
         rem    <= VW'(i_dividend[DW-1:QW]);
         sh     <= i_dividend[QW-1:0];
         dvs    <= i_divisor;
         cnt    <= '0;
         busy   <= 1'b1;
         o_quot <= '0;
      end else if (busy) begin
         rem    <= ge ? trial[VW-1:0] - dvs : trial[VW-1:0];
         sh     <= sh << 1;
         o_quot <= {o_quot[QW-2:0], ge};
         cnt    <= cnt + CW'(1);
         busy   <= ~o_done;
      end
   end
endmodule

// File: rtl/kalman_filter_mc.sv
// kalman_filter_mc: time-multiplexed scalar Kalman filter, CH channels sharing one divider and multiplier.
// Optional innovation gate enabled by defining KALMAN_INNOV_GATE_EN.
module kalman_filter_mc
   import kalman_pkg::*;
#(
   parameter int          W      = 14,
   parameter int          CH     = 4,
   parameter int          FRAC   = FRAC_DEF,
   parameter logic [31:0] P_INIT = P_INIT_DEF
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [3:0]    i_ch,
   input  logic          i_init,
   input  logic [W-1:0]  i_meas,
   input  logic [31:0]   i_kal_Q,
   input  logic [31:0]   i_kal_R,
   output logic          o_valid,
   output logic [3:0]    o_ch,
   output logic [31:0]   o_x,
   output logic [31:0]   o_p,
`ifdef KALMAN_INNOV_GATE_EN
   input  logic [31:0]   i_gate,
   output logic          o_gated,
`endif
   output logic [FRAC:0] o_k
);
   localparam int CW = CH > 1 ? $clog2(CH) : 1;
   localparam int PW = 33 + FRAC;
   localparam logic [FRAC:0] ONE = (FRAC+1)'(1) << FRAC;
   state_t               state, nxt;
   logic                 accept;
   logic [3:0]           ch_r;
   logic                 init_r;
   logic [W-1:0]         meas_r;
   logic [31:0]          q_r, r_r;
   logic signed [31:0]   x_mem [CH];
   logic [31:0]          p_mem [CH];
   logic [CW-1:0]        idx;
   logic                 ch_ok;
   logic signed [31:0]   x_cur;
   logic [31:0]          p_cur, p_pri_c, d_c, p_pri_r, d_r;
   logic signed [32:0]   err_r;
   logic [FRAC:0]        quot, k_c, omk, k_fin, k_r;
   logic                 div_done;
   logic signed [47:0]   prod, x_sum;
   logic [31:0]          x_c, p_c, x_fin, p_fin, x_new_r, p_new_r;
   logic                 gated_c;
`ifdef KALMAN_INNOV_GATE_EN
   logic [31:0]          gate_r;
   logic [32:0]          abs_err;
   logic                 gated_r;
   assign abs_err = err_r[32] ? 33'(-err_r) : 33'(err_r);
   assign gated_c = !init_r && abs_err > {1'b0, gate_r};
`else
   assign gated_c = 1'b0;
`endif
   assign o_ready = state == IDLE;
   assign accept  = i_valid && state == IDLE;
   assign idx     = ch_r[CW-1:0];
   assign ch_ok   = 5'(ch_r) < 5'(CH);
   assign x_cur   = x_mem[idx];
   assign p_cur   = p_mem[idx];
   assign p_pri_c = sat_add(p_cur, q_r);
   assign d_c     = sat_add(p_pri_c, r_r);

   kalman_div_seq #(.DW(32 + FRAC), .VW(32), .QW(FRAC + 1)) u_div (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_start    (state == PRED),
      .i_dividend ({p_pri_c, {FRAC{1'b0}}}),
      .i_divisor  (d_c),
      .o_done     (div_done),
      .o_quot     (quot)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else state <= nxt;
   end

   // Next state; init samples skip the filter math but still pass through UPD, landing two edges after accept.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = i_valid ? (i_init ? UPD : PRED) : IDLE;
         PRED:    nxt = DIV;
         DIV:     nxt = div_done ? UPD : DIV;
         UPD:     nxt = OUT;
         OUT:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Update arithmetic: gain, floored innovation correction with saturation, covariance shrink.
   always_comb begin
      k_c   = d_r == '0 ? '0 : quot;
      omk   = ONE - k_c;
      prod  = 48'(k_c) * 48'(err_r);
      x_sum = 48'(x_cur) + (prod >>> FRAC);
      x_c   = (x_sum[47:31] == '0 || x_sum[47:31] == '1) ? x_sum[31:0]
            : (x_sum[47] ? 32'h8000_0000 : 32'h7fff_ffff);
      p_c   = 32'((PW'(omk) * PW'(p_pri_r)) >> FRAC);
      x_fin = init_r ? 32'($signed(meas_r)) : gated_c ? x_cur : x_c;
      p_fin = init_r ? P_INIT : gated_c ? p_pri_r : p_c;
      k_fin = (init_r || gated_c) ? '0 : k_c;
   end

   // Input latch, prediction capture, result capture and per-channel write-back.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < CH; i++) begin
            x_mem[i] <= '0;
            p_mem[i] <= P_INIT;
         end
         ch_r    <= '0;
         init_r  <= 1'b0;
         meas_r  <= '0;
         q_r     <= Q_DEF;
         r_r     <= R_DEF;
         p_pri_r <= '0;
         d_r     <= '0;
         err_r   <= '0;
         x_new_r <= '0;
         p_new_r <= P_INIT;
         k_r     <= '0;
         o_valid <= 1'b0;
         o_ch    <= '0;
         o_x     <= '0;
         o_p     <= P_INIT;
         o_k     <= '0;
`ifdef KALMAN_INNOV_GATE_EN
         gate_r  <= '0;
         gated_r <= 1'b0;
         o_gated <= 1'b0;
`endif
      end else begin
         o_valid <= 1'b0;
`ifdef KALMAN_INNOV_GATE_EN
         o_gated <= 1'b0;
`endif
         if (accept) begin
            ch_r   <= i_ch;
            init_r <= i_init;
            meas_r <= i_meas;
            q_r    <= i_kal_Q;
            r_r    <= i_kal_R;
`ifdef KALMAN_INNOV_GATE_EN
            gate_r <= i_gate;
`endif
         end
         if (state == PRED) begin
            p_pri_r <= p_pri_c;
            d_r     <= d_c;
            err_r   <= 33'($signed(meas_r)) - 33'(x_cur);
         end
         if (state == UPD) begin
            x_new_r <= x_fin;
            p_new_r <= p_fin;
            k_r     <= k_fin;
`ifdef KALMAN_INNOV_GATE_EN
            gated_r <= gated_c;
`endif
         end
         if (state == OUT && ch_ok) begin
            x_mem[idx] <= x_new_r;
            p_mem[idx] <= p_new_r;
            o_valid    <= 1'b1;
            o_ch       <= ch_r;
            o_x        <= x_new_r;
            o_p        <= p_new_r;
            o_k        <= k_r;
`ifdef KALMAN_INNOV_GATE_EN
            o_gated    <= gated_r;
`endif
         end
      end
   end
endmodule

// File: tb/tb_kalman_filter_mc.sv
// tb_kalman_filter_mc: directed bench for kalman_filter_mc; gate scenario under KALMAN_INNOV_GATE_EN
module tb_kalman_filter_mc;
   logic        i_clk = 1'b0;
   logic        i_rst, i_valid, i_init;
   logic [3:0]  i_ch;
   logic [13:0] i_meas;
   logic [31:0] i_kal_Q, i_kal_R;
   logic        o_ready, o_valid;
   logic [3:0]  o_ch;
   logic [31:0] o_x, o_p;
   logic [13:0] o_k;
`ifdef KALMAN_INNOV_GATE_EN
   logic [31:0] i_gate;
   logic        o_gated;
`endif
   int checks = 0;
   int passes = 0;
   int lat;

   kalman_filter_mc dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_ch    (i_ch),
      .i_init  (i_init),
      .i_meas  (i_meas),
      .i_kal_Q (i_kal_Q),
      .i_kal_R (i_kal_R),
      .o_valid (o_valid),
      .o_ch    (o_ch),
      .o_x     (o_x),
      .o_p     (o_p),
`ifdef KALMAN_INNOV_GATE_EN
      .i_gate  (i_gate),
      .o_gated (o_gated),
`endif
      .o_k     (o_k)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      tick();
      tick();
      i_rst = 1'b0;
   endtask

   // Accept one sample, then wait (bounded) for its result strobe; lat=-1 on timeout.
   task automatic send(input logic [3:0] c, input logic ini, input logic [13:0] m);
      i_ch = c; i_init = ini; i_meas = m; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40 && lat < 0; n++) begin
         tick();
         if (o_valid) lat = n;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (o_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", o_valid); else passes++;
      checks++; if (o_ready !== 1'b1) $display("FAIL rst_ready got %0b want 1", o_ready); else passes++;
      checks++; if (o_x !== 32'd0) $display("FAIL rst_x got %0d want 0", o_x); else passes++;
      checks++; if (o_p !== 32'd100000) $display("FAIL rst_p got %0d want 100000", o_p); else passes++;
      checks++; if (o_k !== 14'd0) $display("FAIL rst_k got %0d want 0", o_k); else passes++;
      checks++; if (o_ch !== 4'd0) $display("FAIL rst_ch got %0d want 0", o_ch); else passes++;
   endtask

   task automatic test_first_sample();
      send(4'd0, 1'b0, 14'd1000);
      checks++; if (lat !== 17) $display("FAIL first_lat got %0d want 17", lat); else passes++;
      checks++; if (o_x !== 32'd999) $display("FAIL first_x got %0d want 999", o_x); else passes++;
      checks++; if (o_p !== 32'd12) $display("FAIL first_p got %0d want 12", o_p); else passes++;
      checks++; if (o_k !== 14'd8191) $display("FAIL first_k got %0d want 8191", o_k); else passes++;
      checks++; if (o_ch !== 4'd0) $display("FAIL first_ch got %0d want 0", o_ch); else passes++;
      checks++; if (o_ready !== 1'b1) $display("FAIL first_ready got %0b want 1", o_ready); else passes++;
   endtask

   task automatic test_repeat_sample();
      send(4'd0, 1'b0, 14'd1000);
      checks++; if (o_k !== 14'd5157) $display("FAIL repeat_k got %0d want 5157", o_k); else passes++;
      checks++; if (o_x !== 32'd999) $display("FAIL repeat_x got %0d want 999", o_x); else passes++;
      checks++; if (o_p !== 32'd6) $display("FAIL repeat_p got %0d want 6", o_p); else passes++;
      tick();
      checks++; if (o_valid !== 1'b0) $display("FAIL repeat_pulse got %0b want 0", o_valid); else passes++;
   endtask

   task automatic test_negative_floor();
      do_reset();
      send(4'd1, 1'b0, -14'sd1000);
      checks++; if (o_x !== 32'hffff_fc18) $display("FAIL neg_x got %0d want -1000", $signed(o_x)); else passes++;
      checks++; if (o_p !== 32'd12) $display("FAIL neg_p got %0d want 12", o_p); else passes++;
      checks++; if (o_ch !== 4'd1) $display("FAIL neg_ch got %0d want 1", o_ch); else passes++;
      send(4'd0, 1'b0, 14'd1000);
      checks++; if (o_k !== 14'd8191) $display("FAIL neg_ch0_k got %0d want 8191", o_k); else passes++;
      checks++; if (o_x !== 32'd999) $display("FAIL neg_ch0_x got %0d want 999", o_x); else passes++;
   endtask

   task automatic test_init();
      send(4'd2, 1'b1, 14'd300);
      checks++; if (lat !== 2) $display("FAIL init_lat got %0d want 2", lat); else passes++;
      checks++; if (o_x !== 32'd300) $display("FAIL init_x got %0d want 300", o_x); else passes++;
      checks++; if (o_p !== 32'd100000) $display("FAIL init_p got %0d want 100000", o_p); else passes++;
      checks++; if (o_k !== 14'd0) $display("FAIL init_k got %0d want 0", o_k); else passes++;
      checks++; if (o_ch !== 4'd2) $display("FAIL init_ch got %0d want 2", o_ch); else passes++;
      send(4'd2, 1'b0, 14'd300);
      checks++; if (o_x !== 32'd300 || o_p !== 32'd12) $display("FAIL init_follow x=%0d p=%0d want 300 12", o_x, o_p); else passes++;
   endtask

   task automatic test_out_of_range();
      int  n;
      logic seen;
      i_ch = 4'd5; i_init = 1'b0; i_meas = 14'd1000; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      n = 0; seen = 1'b0;
      while (!o_ready && n < 40) begin
         tick();
         n++;
         if (o_valid) seen = 1'b1;
      end
      checks++; if (n !== 17) $display("FAIL oor_busy got %0d want 17", n); else passes++;
      checks++; if (seen !== 1'b0) $display("FAIL oor_valid got %0b want 0", seen); else passes++;
      checks++; if (o_x !== 32'd300) $display("FAIL oor_hold_x got %0d want 300", o_x); else passes++;
   endtask

   task automatic test_back_to_back();
      int  n;
      logic early;
      i_ch = 4'd3; i_init = 1'b0; i_meas = 14'd1000; i_valid = 1'b1;
      tick();
      n = 0; early = 1'b0;
      while (!o_valid && n < 40) begin
         if (o_ready) early = 1'b1;
         tick();
         n++;
      end
      checks++; if (early !== 1'b0) $display("FAIL b2b_ready_early got %0b want 0", early); else passes++;
      checks++; if (n !== 17) $display("FAIL b2b_lat1 got %0d want 17", n); else passes++;
      checks++; if (o_ready !== 1'b1) $display("FAIL b2b_ready_at_valid got %0b want 1", o_ready); else passes++;
      checks++; if (o_x !== 32'd999) $display("FAIL b2b_x1 got %0d want 999", o_x); else passes++;
      tick();
      i_valid = 1'b0;
      checks++; if (o_ready !== 1'b0) $display("FAIL b2b_second_accept got %0b want 0", o_ready); else passes++;
      n = 0;
      while (!o_valid && n < 40) begin
         tick();
         n++;
      end
      checks++; if (n !== 17) $display("FAIL b2b_lat2 got %0d want 17", n); else passes++;
      checks++; if (o_k !== 14'd5157) $display("FAIL b2b_k2 got %0d want 5157", o_k); else passes++;
      checks++; if (o_p !== 32'd6) $display("FAIL b2b_p2 got %0d want 6", o_p); else passes++;
   endtask

   task automatic test_reset_mid();
      logic seen;
      i_ch = 4'd0; i_init = 1'b0; i_meas = 14'd1000; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      repeat (8) tick();
      i_rst = 1'b1;
      tick();
      checks++; if (o_valid !== 1'b0) $display("FAIL mid_valid got %0b want 0", o_valid); else passes++;
      checks++; if (o_ready !== 1'b1) $display("FAIL mid_ready got %0b want 1", o_ready); else passes++;
      checks++; if (o_x !== 32'd0 || o_p !== 32'd100000) $display("FAIL mid_outs x=%0d p=%0d want 0 100000", o_x, o_p); else passes++;
      i_rst = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         tick();
         if (o_valid) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) $display("FAIL mid_lost got %0b want 0", seen); else passes++;
      send(4'd0, 1'b0, 14'd1000);
      checks++; if (o_k !== 14'd8191) $display("FAIL mid_after_k got %0d want 8191", o_k); else passes++;
      checks++; if (o_x !== 32'd999 || o_p !== 32'd12) $display("FAIL mid_after x=%0d p=%0d want 999 12", o_x, o_p); else passes++;
   endtask

`ifdef KALMAN_INNOV_GATE_EN
   task automatic test_gate();
      do_reset();
      send(4'd0, 1'b0, 14'd1000);
      checks++; if (o_gated !== 1'b0 || o_x !== 32'd999) $display("FAIL gate_pass g=%0b x=%0d want 0 999", o_gated, o_x); else passes++;
      i_gate = 32'd100;
      send(4'd0, 1'b0, 14'd5000);
      checks++; if (lat !== 17) $display("FAIL gate_lat got %0d want 17", lat); else passes++;
      checks++; if (o_gated !== 1'b1) $display("FAIL gate_flag got %0b want 1", o_gated); else passes++;
      checks++; if (o_x !== 32'd999) $display("FAIL gate_x got %0d want 999", o_x); else passes++;
      checks++; if (o_p !== 32'd17) $display("FAIL gate_p got %0d want 17", o_p); else passes++;
      checks++; if (o_k !== 14'd0) $display("FAIL gate_k got %0d want 0", o_k); else passes++;
      tick();
      checks++; if (o_gated !== 1'b0) $display("FAIL gate_pulse got %0b want 0", o_gated); else passes++;
   endtask
`endif

   initial begin
      i_rst = 1'b1; i_valid = 1'b0; i_init = 1'b0; i_ch = 4'd0; i_meas = 14'd0;
      i_kal_Q = 32'd5; i_kal_R = 32'd10;
`ifdef KALMAN_INNOV_GATE_EN
      i_gate = 32'hffff_ffff;
`endif
      test_reset();
      test_first_sample();
      test_repeat_sample();
      test_negative_floor();
      test_init();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid();
`ifdef KALMAN_INNOV_GATE_EN
      test_gate();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
